// File: rtl/dp_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dp_rr_arbiter
//
// Shares one short-latency logic datapath unit between N_REQ requesters.
// A round-robin pick is made in IDLE. The winner's operands and opcode are
// captured into registers, and a one-cycle issue strobe is sent to the
// datapath. The block then waits for the datapath completion strobe, with a
// watchdog guarding the wait. The result, or a timeout error, goes back to the
// granted requester as a one-cycle done pulse.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_req                  per-requester request level
//   i_opa, i_opb, i_op     packed per-requester operands / opcode
//   o_gnt                  one-hot grant, held from ISSUE through RESP
//   o_done                 one-hot one-cycle completion pulse
//   o_result, o_err        result and timeout flag, valid with o_done
//   o_dp_a/b/op            registered operands / opcode to the datapath
//   o_dp_valid             one-cycle issue strobe to the datapath
//   i_dp_result, i_dp_done datapath result and completion strobe
//   o_busy                 high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dp_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_opa,
  input  logic [N_REQ*DATA_W-1:0]   i_opb,
  input  logic [N_REQ*OP_W-1:0]     i_op,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [N_REQ-1:0]          o_done,
  output logic [DATA_W-1:0]         o_result,
  output logic                      o_err,
  output logic [DATA_W-1:0]         o_dp_a,
  output logic [DATA_W-1:0]         o_dp_b,
  output logic [OP_W-1:0]           o_dp_op,
  output logic                      o_dp_valid,
  input  logic [DATA_W-1:0]         i_dp_result,
  input  logic                      i_dp_done,
  output logic                      o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic [IDX_W-1:0]    ptr_q,      ptr_d;
  logic [IDX_W-1:0]    gidx_q,     gidx_d;
  logic [7:0]          wd_q,       wd_d;
  logic [N_REQ-1:0]    gnt_q,      gnt_d;
  logic [N_REQ-1:0]    done_q,     done_d;
  logic [DATA_W-1:0]   result_q,   result_d;
  logic                err_q,      err_d;
  logic [DATA_W-1:0]   dp_a_q,     dp_a_d;
  logic [DATA_W-1:0]   dp_b_q,     dp_b_d;
  logic [OP_W-1:0]     dp_op_q,    dp_op_d;
  logic                dp_valid_q, dp_valid_d;
  logic                busy_q,     busy_d;

  logic                found_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic [IDX_W-1:0]    ptr_nxt_s;
  logic [7:0]          wd_inc_s;

  // Round-robin pick: the scan runs from the farthest offset down to offset 0.
  // Because each later hit overwrites the earlier one, the surviving
  // selection is the first set bit at or after the pointer, wrapping past the
  // top.
  always_comb begin
    sel_idx_s = '0;
    found_s   = |i_req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int               cand;
      logic [IDX_W-1:0] cidx;
      cand      = (int'(ptr_q) + i) % N_REQ;
      cidx      = IDX_W'(cand);
      sel_idx_s = i_req[cidx] ? cidx : sel_idx_s;
    end
  end

  // Pointer successor of the granted requester, wrapping at N_REQ-1.
  always_comb begin
    if (gidx_q == IDX_W'(N_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gidx_q + IDX_W'(1);
    end
  end

  assign wd_inc_s = wd_q + 8'd1;

  // Next-state and next-output logic. Every register holds by default.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    wd_d       = wd_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    result_d   = result_q;
    err_d      = err_q;
    dp_a_d     = dp_a_q;
    dp_b_d     = dp_b_q;
    dp_op_d    = dp_op_q;
    dp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          gidx_d     = sel_idx_s;
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
          dp_a_d     = i_opa[sel_idx_s*DATA_W +: DATA_W];
          dp_b_d     = i_opb[sel_idx_s*DATA_W +: DATA_W];
          dp_op_d    = i_op[sel_idx_s*OP_W +: OP_W];
          dp_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ISSUE: begin
        wd_d    = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_inc_s;
        // A completion that lands on the timeout cycle takes priority.
        if (i_dp_done) begin
          result_d = i_dp_result;
          err_d    = 1'b0;
          done_d   = gnt_q;
          state_d  = S_RESP;
        end else if (wd_inc_s == TIMEOUT_C) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = gnt_q;
          state_d  = S_RESP;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_RESP: begin
        ptr_d    = ptr_nxt_s;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        result_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        result_d = '0;
        state_d  = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. An asynchronous reset aborts silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      wd_q       <= 8'd0;
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_op_q    <= '0;
      dp_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      wd_q       <= wd_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_q      <= err_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      dp_op_q    <= dp_op_d;
      dp_valid_q <= dp_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_err      = err_q;
  assign o_dp_a     = dp_a_q;
  assign o_dp_b     = dp_b_q;
  assign o_dp_op    = dp_op_q;
  assign o_dp_valid = dp_valid_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_dp_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dp_rr_arbiter
//
// Self-checking bench for dp_rr_arbiter (N_REQ=4, DATA_W=8, OP_W=2,
// TIMEOUT=15). The bench acts as both the requesters and the datapath.
// Directed vectors come from a table. Randomized transactions are checked
// against a transaction-level model: a pointer integer plus a wrap-around
// first-set search, and a logic-function datapath. A hand-written sequence
// covers reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_dp_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 15;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [7:0]  op;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        err;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic [1:0]  dp_op;
  logic        dp_valid;
  logic [7:0]  dp_result;
  logic        dp_done;
  logic        busy;

  int errors;
  int checks;
  int ptr_m;

  logic [7:0] lane_a  [4];
  logic [7:0] lane_b  [4];
  logic [1:0] lane_op [4];

  dp_rr_arbiter #(.N_REQ(4), .DATA_W(8), .OP_W(2), .TIMEOUT(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_opa       (opa),
    .i_opb       (opb),
    .i_op        (op),
    .o_gnt       (gnt),
    .o_done      (done),
    .o_result    (result),
    .o_err       (err),
    .o_dp_a      (dp_a),
    .o_dp_b      (dp_b),
    .o_dp_op     (dp_op),
    .o_dp_valid  (dp_valid),
    .i_dp_result (dp_result),
    .i_dp_done   (dp_done),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath behaviour: 0 NAND, 1 AND, 2 OR, 3 XOR.
  function automatic logic [7:0] dp_f(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      2'd0:    return ~(a & b);
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Round-robin reference: the first set request at or after p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (p + i) % N;
      if (r[c[1:0]]) return c;
    end
    return 0;
  endfunction

  task automatic drive_lanes();
    for (int k = 0; k < N; k++) begin
      opa[k*8 +: 8] = lane_a[k];
      opb[k*8 +: 8] = lane_b[k];
      op[k*2 +: 2]  = lane_op[k];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt),      32'h0);
    chk({tag, "_done"},  32'(done),     32'h0);
    chk({tag, "_res"},   32'(result),   32'h0);
    chk({tag, "_err"},   32'(err),      32'h0);
    chk({tag, "_dpa"},   32'(dp_a),     32'h0);
    chk({tag, "_dpb"},   32'(dp_b),     32'h0);
    chk({tag, "_dpop"},  32'(dp_op),    32'h0);
    chk({tag, "_valid"}, 32'(dp_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy),     32'h0);
  endtask

  // A single transaction. The task is entered #1 into an IDLE cycle and
  // returns #1 into the IDLE cycle that follows RESP.
  task automatic txn(input logic [3:0] rq, input logic [3:0] eg, input int delay,
                     input logic [7:0] dpres, input logic [7:0] eres, input logic eerr,
                     input logic late);
    int         g;
    int         last;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [1:0] eop;
    g = 0;
    for (int k = 0; k < N; k++) if (eg[k]) g = k;
    ea  = lane_a[g];
    eb  = lane_b[g];
    eop = lane_op[g];
    req = rq;
    drive_lanes();
    dp_done   = 1'b0;
    dp_result = 8'h00;

    @(posedge clk); #1;
    chk("issue_gnt",   32'(gnt),      32'(eg));
    chk("issue_valid", 32'(dp_valid), 32'h1);
    chk("issue_dpa",   32'(dp_a),     32'(ea));
    chk("issue_dpb",   32'(dp_b),     32'(eb));
    chk("issue_dpop",  32'(dp_op),    32'(eop));
    chk("issue_busy",  32'(busy),     32'h1);
    chk("issue_done",  32'(done),     32'h0);
    // Operands change after capture and must not disturb the in-flight op.
    opa = $urandom;
    opb = $urandom;
    op  = 8'($urandom);

    last = (delay < TMO) ? delay : TMO;
    for (int w = 1; w <= last; w++) begin
      @(posedge clk); #1;
      chk("wait_valid", 32'(dp_valid), 32'h0);
      chk("wait_done",  32'(done),     32'h0);
      chk("wait_gnt",   32'(gnt),      32'(eg));
      chk("wait_dpa",   32'(dp_a),     32'(ea));
      if (w == delay) begin
        dp_done   = 1'b1;
        dp_result = dpres;
      end
    end

    @(posedge clk); #1;
    dp_done   = 1'b0;
    dp_result = 8'h00;
    chk("resp_done", 32'(done),   32'(eg));
    chk("resp_res",  32'(result), 32'(eres));
    chk("resp_err",  32'(err),    32'(eerr));
    chk("resp_gnt",  32'(gnt),    32'(eg));
    chk("resp_busy", 32'(busy),   32'h1);
    if (late) begin
      dp_done   = 1'b1;
      dp_result = 8'hAA;
    end
    req = rq & ~eg;

    @(posedge clk); #1;
    chk("idle_done",  32'(done),     32'h0);
    chk("idle_gnt",   32'(gnt),      32'h0);
    chk("idle_err",   32'(err),      32'h0);
    chk("idle_busy",  32'(busy),     32'h0);
    chk("idle_valid", 32'(dp_valid), 32'h0);
    ptr_m = (g + 1) % N;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    int         delay;
    logic [7:0] dpres;
    logic [3:0] eg;
    logic [7:0] eres;
    logic       eerr;
    logic       late;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [3:0] pend;
    int         g;
    int         d;
    logic [7:0] r;

    errors = 0;
    checks = 0;
    ptr_m  = 0;

    //               req      a      b      op    dly  dpres  gnt      eres   err   late
    tbl[0]  = '{4'b1111, 8'h11, 8'h22, 2'd0,  1, 8'h01, 4'b0001, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 8'h33, 8'h44, 2'd1,  2, 8'h02, 4'b0010, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{4'b1111, 8'h55, 8'h66, 2'd2,  1, 8'h03, 4'b0100, 8'h03, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 8'h77, 8'h88, 2'd3,  3, 8'h04, 4'b1000, 8'h04, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 8'h99, 8'hAA, 2'd0,  1, 8'h05, 4'b0001, 8'h05, 1'b0, 1'b0};
    tbl[5]  = '{4'b0010, 8'hF0, 8'h3C, 2'd0,  1, 8'hCF, 4'b0010, 8'hCF, 1'b0, 1'b0};
    tbl[6]  = '{4'b0100, 8'h12, 8'h34, 2'd1,  1, 8'h10, 4'b0100, 8'h10, 1'b0, 1'b0};
    tbl[7]  = '{4'b0101, 8'h56, 8'h78, 2'd2,  1, 8'h7E, 4'b0001, 8'h7E, 1'b0, 1'b0};
    tbl[8]  = '{4'b0101, 8'h9A, 8'hBC, 2'd3,  1, 8'h26, 4'b0100, 8'h26, 1'b0, 1'b0};
    tbl[9]  = '{4'b1000, 8'hDE, 8'hF0, 2'd0, 20, 8'h77, 4'b1000, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{4'b0001, 8'h0F, 8'hF0, 2'd1, 15, 8'h5A, 4'b0001, 8'h5A, 1'b0, 1'b0};
    tbl[11] = '{4'b0110, 8'hC3, 8'h3C, 2'd2, 14, 8'hC3, 4'b0010, 8'hC3, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req       = 4'b0000;
    opa       = 32'h0;
    opb       = 32'h0;
    op        = 8'h0;
    dp_done   = 1'b0;
    dp_result = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Idle with no request: the FSM stays put.
    @(posedge clk); #1;
    chk("noreq_busy", 32'(busy), 32'h0);
    chk("noreq_gnt",  32'(gnt),  32'h0);

    // Directed table: round-robin, single request, wrap, timeout, collision.
    for (int t = 0; t < 12; t++) begin
      int gi;
      gi = 0;
      for (int k = 0; k < N; k++) if (tbl[t].eg[k]) gi = k;
      for (int k = 0; k < N; k++) begin
        lane_a[k]  = ~tbl[t].a;
        lane_b[k]  = ~tbl[t].b;
        lane_op[k] = ~tbl[t].op;
      end
      lane_a[gi]  = tbl[t].a;
      lane_b[gi]  = tbl[t].b;
      lane_op[gi] = tbl[t].op;
      txn(tbl[t].req, tbl[t].eg, tbl[t].delay, tbl[t].dpres,
          tbl[t].eres, tbl[t].eerr, tbl[t].late);
    end

    // Randomized: held requests accumulate; each grant is predicted by the model.
    pend = 4'b0000;
    for (int it = 0; it < 120; it++) begin
      pend = pend | 4'($urandom);
      if (pend == 4'b0000) pend = 4'b0001 << $urandom_range(0, 3);
      for (int k = 0; k < N; k++) begin
        lane_a[k]  = 8'($urandom);
        lane_b[k]  = 8'($urandom);
        lane_op[k] = 2'($urandom);
      end
      g = pick(pend, ptr_m);
      d = int'($urandom_range(1, 18));
      r = dp_f(lane_op[g], lane_a[g], lane_b[g]);
      txn(pend, 4'b0001 << g, d, r, (d <= TMO) ? r : 8'h00, (d > TMO), (d > TMO));
      pend = pend & ~(4'b0001 << g);
      if ($urandom_range(0, 3) == 0) begin
        req = 4'b0000;
        @(posedge clk); #1;
        chk("gap_busy", 32'(busy), 32'h0);
      end
    end

    // Reset in the middle of WAIT: outputs clear at once, and the pointer
    // returns to 0.
    for (int k = 0; k < N; k++) begin
      lane_a[k]  = 8'(8'h20 + k);
      lane_b[k]  = 8'(8'h40 + k);
      lane_op[k] = 2'(k);
    end
    txn(4'b0010, 4'b0010, 1, 8'h11, 8'h11, 1'b0, 1'b0);
    req = 4'b1111;
    drive_lanes();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("prerst_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    chk("inrst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    ptr_m = 0;
    chk("postrst_busy", 32'(busy), 32'h0);
    g = pick(4'b1111, ptr_m);
    txn(4'b1111, 4'b0001 << g, 1, 8'h3E, 8'h3E, 1'b0, 1'b0);
    chk("postrst_ptr_model", 32'(g), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_rr_arbiter.md
Name: dp_rr_arbiter

Overview:
- Shares one combinational/short-latency logic datapath unit (NAND/AND/OR/XOR family) between N_REQ requesters.
- Round-robin arbitration, operand capture and issue, completion wait with watchdog, and result return to the granted requester.
- Sits between requester ports and the shared datapath unit's operand/result interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width.
- OP_W, 2, datapath opcode width.
- TIMEOUT, 15, max WAIT cycles before abort (1..255).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  N_REQ  per-requester request level.
- i_opa  in  N_REQ*DATA_W  operand A, requester k at bits [k*DATA_W +: DATA_W].
- i_opb  in  N_REQ*DATA_W  operand B, same packing.
- i_op  in  N_REQ*OP_W  opcode, requester k at [k*OP_W +: OP_W].
- o_gnt  out  N_REQ  one-hot grant, held ISSUE..RESP.
- o_done  out  N_REQ  one-hot one-cycle completion pulse.
- o_result  out  DATA_W  result, valid while o_done nonzero.
- o_err  out  1  timeout flag, valid with o_done.
- o_dp_a, o_dp_b  out  DATA_W  operands to datapath (registered).
- o_dp_op  out  OP_W  opcode to datapath.
- o_dp_valid  out  1  one-cycle issue strobe.
- i_dp_result  in  DATA_W  datapath result.
- i_dp_done  in  1  datapath completion strobe.
- o_busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (i_rst_n low, async): state IDLE; o_gnt, o_done, o_result, o_err, o_dp_a/b/op, o_dp_valid, o_busy all 0; RR pointer = 0; watchdog = 0. Reset mid-operation aborts silently: no o_done pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any i_req bit set, pick the first set bit searching from pointer upward with wrap (pointer, pointer+1, ..., N_REQ-1, 0, ...). Capture that requester's operands/opcode into o_dp_a/b/op, set o_gnt, go to ISSUE. Otherwise stay.
- ISSUE: o_dp_valid=1 for exactly this cycle; watchdog cleared; go to WAIT.
- WAIT: watchdog increments each cycle.
  - i_dp_done=1: capture i_dp_result into o_result, o_err=0, go to RESP.
  - Watchdog reaches TIMEOUT without done: o_result=0, o_err=1, go to RESP.
  - i_dp_done and timeout in the same cycle: done wins (o_err=0).
- RESP: o_done = o_gnt for one cycle; pointer = (granted index + 1) mod N_REQ. Next cycle: o_gnt=0, o_done=0, o_err=0, go to IDLE.
- Latency: minimum 4 cycles from i_req seen in IDLE to o_done (IDLE->ISSUE->WAIT with done->RESP). Back-to-back grants separated by one IDLE cycle.
- i_dp_done outside WAIT is ignored.
- Requesters hold i_req until their o_done. i_req or operands changing after capture do not affect the in-flight operation; o_done still pulses for the granted requester.
- Requests arriving during a grant wait until the next IDLE; no request is lost while held.
- Fairness: a continuously requesting requester waits at most N_REQ-1 other grants.

Test Plan:
- Reset: assert i_rst_n=0 mid-WAIT -> all outputs 0 immediately; after release, state IDLE and pointer 0.
- Single request: i_req=4'b0010, opa=8'hF0, opb=8'h3C, op=2'd0; datapath returns 8'hCF one cycle after o_dp_valid -> o_gnt=0010, o_dp_a=F0, o_dp_b=3C, o_done=0010 with o_result=CF, o_err=0; total 4 cycles.
- Round-robin: i_req=4'b1111 held; each done returned immediately -> grant order 0001, 0010, 0100, 1000, 0001.
- Wrap: pointer=3 after granting 2; i_req=4'b0101 -> next grant 0001, then 0100.
- Timeout: TIMEOUT=15, no i_dp_done -> o_done pulses with o_err=1, o_result=0 on WAIT cycle 15; a late i_dp_done afterwards is ignored.
- Collision: i_dp_done high on the same cycle the watchdog hits TIMEOUT with result 8'h5A -> o_err=0, o_result=5A.
